// File: rtl/seq_code_checker.sv
// ============================================================================
// Module   : seq_code_checker
// Function : Lock/integrity monitor for the 000->011->101->110 code stream.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_code_checker #(
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       code_in,
  input  logic             code_valid,
  output logic             locked,
  output logic [1:0]       index,
  output logic             err,
  output logic             illegal,
  output logic             wrap,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [3:0] c_LOCK_CNT = 4'(LOCK_CNT);

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_VERIFY = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t           state_q;
  logic [2:0]       expected_q;
  logic [3:0]       match_cnt_q;
  logic             locked_q;
  logic [1:0]       index_q;
  logic             err_q;
  logic             illegal_q;
  logic             wrap_q;
  logic [ERR_W-1:0] err_count_q;

  logic             code_legal;
  logic [1:0]       code_pos;
  logic [2:0]       code_next;
  logic [3:0]       match_cnt_d;
  logic [ERR_W-1:0] err_count_d;

  always_comb begin
    code_legal = 1'b1;
    code_pos   = 2'd0;
    code_next  = 3'b011;
    case (code_in)
      3'b000: begin code_pos = 2'd0; code_next = 3'b011; end
      3'b011: begin code_pos = 2'd1; code_next = 3'b101; end
      3'b101: begin code_pos = 2'd2; code_next = 3'b110; end
      3'b110: begin code_pos = 2'd3; code_next = 3'b000; end
      default: code_legal = 1'b0;
    endcase
  end

  assign match_cnt_d = match_cnt_q + 4'd1;
  // Counter holds at all-ones once saturated.
  assign err_count_d = (&err_count_q) ? err_count_q : err_count_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_SEARCH;
      expected_q  <= 3'b000;
      match_cnt_q <= 4'd0;
      locked_q    <= 1'b0;
      index_q     <= 2'd0;
      err_q       <= 1'b0;
      illegal_q   <= 1'b0;
      wrap_q      <= 1'b0;
      err_count_q <= '0;
    end else begin
      err_q     <= 1'b0;
      illegal_q <= 1'b0;
      wrap_q    <= 1'b0;
      if (code_valid) begin
        if (code_legal) index_q <= code_pos;
        case (state_q)
          S_SEARCH: begin
            if (code_legal) begin
              expected_q  <= code_next;
              match_cnt_q <= 4'd0;
              state_q     <= S_VERIFY;
            end else begin
              illegal_q <= 1'b1;
            end
          end
          S_VERIFY: begin
            if (!code_legal) begin
              illegal_q <= 1'b1;
              state_q   <= S_SEARCH;
            end else if (code_in == expected_q) begin
              expected_q  <= code_next;
              match_cnt_q <= match_cnt_d;
              if (match_cnt_d == c_LOCK_CNT) begin
                state_q  <= S_LOCKED;
                locked_q <= 1'b1;
              end
            end else begin
              expected_q  <= code_next;
              match_cnt_q <= 4'd0;
            end
          end
          S_LOCKED: begin
            // expected_q is always a legal code, so equality implies legality.
            if (code_in == expected_q) begin
              expected_q <= code_next;
              if (code_in == 3'b000) wrap_q <= 1'b1;
            end else begin
              err_q       <= 1'b1;
              err_count_q <= err_count_d;
              locked_q    <= 1'b0;
              if (code_legal) begin
                expected_q  <= code_next;
                match_cnt_q <= 4'd0;
                state_q     <= S_VERIFY;
              end else begin
                illegal_q <= 1'b1;
                state_q   <= S_SEARCH;
              end
            end
          end
          default: begin
            state_q  <= S_SEARCH;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign locked    = locked_q;
  assign index     = index_q;
  assign err       = err_q;
  assign illegal   = illegal_q;
  assign wrap      = wrap_q;
  assign err_count = err_count_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_code_checker.sv
// ============================================================================
// Module   : tb_seq_code_checker
// Function : Scoreboard bench for seq_code_checker (LOCK_CNT=4/ERR_W=8 and LOCK_CNT=1/ERR_W=2).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seq_code_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] code_in = 3'b000;
  logic       code_valid = 1'b0;

  logic       a_locked, a_err, a_illegal, a_wrap;
  logic [1:0] a_index;
  logic [7:0] a_err_count;
  logic       b_locked, b_err, b_illegal, b_wrap;
  logic [1:0] b_index;
  logic [1:0] b_err_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_code_checker #(.LOCK_CNT(4), .ERR_W(8)) dut_a (
    .clk(clk), .reset(reset), .code_in(code_in), .code_valid(code_valid),
    .locked(a_locked), .index(a_index), .err(a_err), .illegal(a_illegal),
    .wrap(a_wrap), .err_count(a_err_count)
  );

  seq_code_checker #(.LOCK_CNT(1), .ERR_W(2)) dut_b (
    .clk(clk), .reset(reset), .code_in(code_in), .code_valid(code_valid),
    .locked(b_locked), .index(b_index), .err(b_err), .illegal(b_illegal),
    .wrap(b_wrap), .err_count(b_err_count)
  );

  typedef struct packed {
    logic       lk;
    logic [1:0] ix;
    logic       er;
    logic       il;
    logic       wr;
    logic [7:0] ec;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  // Reference model state, one slot per instance (0 = dut_a, 1 = dut_b).
  int         m_st[2];    // 0 search, 1 verify, 2 locked
  int         m_epos[2];  // expected sequence position
  int         m_cnt[2];
  int         m_ecnt[2];
  logic [1:0] m_idx[2];
  int         m_lockn[2] = '{4, 1};
  int         m_emax[2]  = '{255, 3};
  int         cur = 0;    // stimulus position in the sequence
  int         stepn = 0;

  function automatic logic [2:0] pcode(int p);
    case (p % 4)
      0: return 3'b000;
      1: return 3'b011;
      2: return 3'b101;
      default: return 3'b110;
    endcase
  endfunction

  task automatic model(input int k, input bit r, input bit v, input logic [2:0] c, output exp_t e);
    bit leg;
    int p;
    e = '0;
    if (r) begin
      m_st[k] = 0; m_epos[k] = 0; m_cnt[k] = 0; m_ecnt[k] = 0; m_idx[k] = 2'd0;
    end else if (v) begin
      leg = 1'b0;
      p = 0;
      for (int i = 0; i < 4; i++) if (pcode(i) == c) begin leg = 1'b1; p = i; end
      if (leg) m_idx[k] = 2'(p);
      if (m_st[k] == 0) begin
        if (leg) begin m_epos[k] = (p + 1) % 4; m_cnt[k] = 0; m_st[k] = 1; end
        else e.il = 1'b1;
      end else if (m_st[k] == 1) begin
        if (!leg) begin e.il = 1'b1; m_st[k] = 0; end
        else if (p == m_epos[k]) begin
          m_cnt[k]++;
          m_epos[k] = (p + 1) % 4;
          if (m_cnt[k] == m_lockn[k]) m_st[k] = 2;
        end else begin
          m_cnt[k] = 0;
          m_epos[k] = (p + 1) % 4;
        end
      end else begin
        if (leg && p == m_epos[k]) begin
          m_epos[k] = (p + 1) % 4;
          if (p == 0) e.wr = 1'b1;
        end else begin
          e.er = 1'b1;
          if (m_ecnt[k] < m_emax[k]) m_ecnt[k]++;
          if (leg) begin m_st[k] = 1; m_cnt[k] = 0; m_epos[k] = (p + 1) % 4; end
          else begin e.il = 1'b1; m_st[k] = 0; end
        end
      end
    end
    e.lk = (m_st[k] == 2);
    e.ix = m_idx[k];
    e.ec = 8'(m_ecnt[k]);
  endtask

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s step %0d: observed %0h expected %0h", tag, stepn, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [2:0] c);
    exp_t e;
    reset = r; code_valid = v; code_in = c;
    model(0, r, v, c, e); q_a.push_back(e);
    model(1, r, v, c, e); q_b.push_back(e);
    @(posedge clk);
    #1;
    stepn++;
    e = q_a.pop_front();
    chk("a.locked", {7'd0, a_locked}, {7'd0, e.lk});
    chk("a.index", {6'd0, a_index}, {6'd0, e.ix});
    chk("a.err", {7'd0, a_err}, {7'd0, e.er});
    chk("a.illegal", {7'd0, a_illegal}, {7'd0, e.il});
    chk("a.wrap", {7'd0, a_wrap}, {7'd0, e.wr});
    chk("a.err_count", a_err_count, e.ec);
    e = q_b.pop_front();
    chk("b.locked", {7'd0, b_locked}, {7'd0, e.lk});
    chk("b.index", {6'd0, b_index}, {6'd0, e.ix});
    chk("b.err", {7'd0, b_err}, {7'd0, e.er});
    chk("b.illegal", {7'd0, b_illegal}, {7'd0, e.il});
    chk("b.wrap", {7'd0, b_wrap}, {7'd0, e.wr});
    chk("b.err_count", {6'd0, b_err_count}, e.ec);
    reset = 1'b0; code_valid = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b1, pcode(cur));
      cur = (cur + 1) % 4;
    end
  endtask

  initial begin
    // Reset state
    step(1'b1, 1'b0, 3'b000);
    step(1'b1, 1'b1, 3'b011);

    // Acquisition: 000,011,101,110,000,011
    cur = 0;
    run(6);
    chk("t1.a_locked", {7'd0, a_locked}, 8'd1);

    // Break while 101 is expected, then relock
    step(1'b0, 1'b1, 3'b011);
    chk("t2.a_err_count", a_err_count, 8'd1);
    cur = 2;
    run(4);
    chk("t2.a_relocked", {7'd0, a_locked}, 8'd1);

    // Illegal codes in SEARCH
    step(1'b1, 1'b0, 3'b000);
    step(1'b0, 1'b1, 3'b111);
    step(1'b0, 1'b1, 3'b100);
    chk("t3.a_index", {6'd0, a_index}, 8'd0);

    // Gaps of 1..3 idle cycles while locked
    cur = 0;
    run(5);
    for (int g = 1; g <= 3; g++) begin
      for (int j = 0; j < g; j++) step(1'b0, 1'b0, 3'b111);
      run(1);
    end
    run(1);

    // Five breaks with relock; one break by an illegal code
    step(1'b1, 1'b0, 3'b000);
    cur = 0;
    run(5);
    for (int b = 0; b < 5; b++) begin
      if (b == 2) begin
        step(1'b0, 1'b1, 3'b010);
        cur = 1;
        run(5);
      end else begin
        step(1'b0, 1'b1, pcode(cur + 2));
        cur = (cur + 3) % 4;
        run(4);
      end
    end
    chk("t5.b_err_count_sat", {6'd0, b_err_count}, 8'd3);
    chk("t5.a_err_count", a_err_count, 8'd5);

    // Reset while locked with a valid code present, then reacquire
    step(1'b1, 1'b1, pcode(cur));
    chk("t6.a_locked_after_reset", {7'd0, a_locked}, 8'd0);
    cur = 0;
    run(6);

    if (q_a.size() != 0 || q_b.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d/%0d entries left, expected 0", q_a.size(), q_b.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
